// File: rtl/dm_port_arbiter_if.sv
// Signal bundle between the MEM stage, the debug/loader port and the data memory.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dm_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;

  logic              dm_en;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  logic [31:0]       perf_stall_cnt;
  logic [15:0]       perf_dbg_cnt;

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output dm_en, dm_we, dm_addr, dm_wdata,
    input  dm_rdata,
    output perf_stall_cnt, perf_dbg_cnt
  );

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  dm_en, dm_we, dm_addr, dm_wdata,
    output dm_rdata,
    input  perf_stall_cnt, perf_dbg_cnt
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the MEM stage and a debug/loader requester.
// Optional performance counters are built only when DM_ARB_PERF_EN is defined.
module dm_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WAIT_CYC   = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic              clk,
  input logic              rst_n,
  dm_port_arbiter_if.slave bus
);

  localparam logic [3:0] WaitInit  = 4'(WAIT_CYC);
  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q;
  logic              owner_dbg_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wcnt_q;
  logic [3:0]        starve_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic cpu_win, dbg_win, busy, resp, mem_stall;

  // CPU has priority until it has beaten a waiting debug request StarveLim times in a row.
  assign cpu_win = bus.mem_req && (starve_q < StarveLim);
  assign dbg_win = !cpu_win && bus.dbg_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_dbg_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wcnt_q      <= '0;
      starve_q    <= '0;
      mem_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_win || dbg_win) begin
            state_q     <= StBusy;
            owner_dbg_q <= dbg_win;
            we_q        <= cpu_win ? bus.mem_we    : bus.dbg_we;
            addr_q      <= cpu_win ? bus.mem_addr  : bus.dbg_addr;
            wdata_q     <= cpu_win ? bus.mem_wdata : bus.dbg_wdata;
            wcnt_q      <= WaitInit;
            if (dbg_win) begin
              starve_q <= '0;
            end else if (bus.dbg_req && (starve_q < StarveLim)) begin
              starve_q <= starve_q + 4'd1;
            end
          end
        end
        StBusy: begin
          if (wcnt_q == 4'd0) begin
            state_q <= StResp;
            if (!we_q) begin
              if (owner_dbg_q) dbg_rdata_q <= bus.dm_rdata;
              else             mem_rdata_q <= bus.dm_rdata;
            end
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StBusy);
  assign resp      = (state_q == StResp);
  assign mem_stall = bus.mem_req && !(resp && !owner_dbg_q);

  assign bus.mem_stall = mem_stall;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.dbg_gnt   = busy && owner_dbg_q;
  assign bus.dbg_done  = resp && owner_dbg_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.dm_en     = busy;
  assign bus.dm_we     = busy && we_q;
  assign bus.dm_addr   = addr_q;
  assign bus.dm_wdata  = wdata_q;

`ifdef DM_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] dbg_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      dbg_cnt_q   <= '0;
    end else begin
      if (mem_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == StIdle) && dbg_win) dbg_cnt_q <= dbg_cnt_q + 16'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_dbg_cnt   = dbg_cnt_q;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_dbg_cnt   = '0;
`endif

endmodule
